// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared constants and types for the Y86 stage sequencer
// Purpose: icode constants, processor status codes and the sequencer state encoding.
// Ports: none (package).
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVL = 4'h2;
  localparam logic [3:0] I_IRMOVL = 4'h3;
  localparam logic [3:0] I_RMMOVL = 4'h4;
  localparam logic [3:0] I_MRMOVL = 4'h5;
  localparam logic [3:0] I_OPL    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHL  = 4'hA;
  localparam logic [3:0] I_POPL   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRBACK,
    S_PCUPD,
    S_HALTED,
    S_ERROR
  } state_e;

endpackage

// File: rtl/y86_seq_ctrl_if.sv
// rtl/y86_seq_ctrl_if.sv - sequencer <-> datapath/memory signal bundle
// Purpose: groups the control inputs, stage enables, memory handshake and status.
// Modports: master = sequencer (drives enables/status), slave = datapath side.
interface y86_seq_ctrl_if #(
  parameter int CNT_W = 32
) ();

  logic             run;
  logic [3:0]       icode;
  logic             mem_ready;
  logic             mem_error;
  logic             ld_ir;
  logic             ld_src;
  logic             ld_valE;
  logic             set_cc;
  logic             ld_valM;
  logic             rf_we;
  logic             ld_pc;
  logic             mem_req;
  logic             mem_wr;
  logic [2:0]       stat;
  logic             busy;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  run, icode, mem_ready, mem_error,
    output ld_ir, ld_src, ld_valE, set_cc, ld_valM, rf_we, ld_pc,
           mem_req, mem_wr, stat, busy, instr_count
  );

  modport slave (
    output run, icode, mem_ready, mem_error,
    input  ld_ir, ld_src, ld_valE, set_cc, ld_valM, rf_we, ld_pc,
           mem_req, mem_wr, stat, busy, instr_count
  );

endinterface

// File: rtl/y86_icode_class.sv
// rtl/y86_icode_class.sv - combinational icode classifier
// Purpose: tells the sequencer which stages and memory direction an instruction needs.
// Ports: icode_i (4) in; valid_o, needs_mem_o, mem_rd_o, mem_wr_o, writes_reg_o, sets_cc_o out.
module y86_icode_class
  import y86_pkg::*;
(
  input  logic [3:0] icode_i,
  output logic       valid_o,
  output logic       needs_mem_o,
  output logic       mem_rd_o,
  output logic       mem_wr_o,
  output logic       writes_reg_o,
  output logic       sets_cc_o
);

  always_comb begin
    valid_o      = (icode_i <= I_POPL);
    mem_rd_o     = (icode_i == I_MRMOVL) || (icode_i == I_RET) || (icode_i == I_POPL);
    mem_wr_o     = (icode_i == I_RMMOVL) || (icode_i == I_CALL) || (icode_i == I_PUSHL);
    needs_mem_o  = mem_rd_o || mem_wr_o;
    writes_reg_o = (icode_i == I_RRMOVL) || (icode_i == I_IRMOVL) ||
                   (icode_i == I_MRMOVL) || (icode_i == I_OPL)    ||
                   (icode_i == I_CALL)   || (icode_i == I_RET)    ||
                   (icode_i == I_PUSHL)  || (icode_i == I_POPL);
    sets_cc_o    = (icode_i == I_OPL);
  end

endmodule

// File: rtl/y86_seq_ctrl.sv
// rtl/y86_seq_ctrl.sv - multicycle stage sequencer for the simple Y86 datapath
// Purpose: steps FETCH/DECODE/EXECUTE/MEMORY/WRBACK/PCUPD, drives per-stage load enables,
//   owns the memory request handshake, processor status and retired-instruction count.
// Ports: clk, reset (async, active-high); bus (y86_seq_ctrl_if.master) carrying run, icode,
//   mem_ready, mem_error in and ld_ir..ld_pc, mem_req, mem_wr, stat, busy, instr_count out.
// Option: MEM_TIMEOUT_EN adds a per-request wait counter that errors out after TIMEOUT waits.
module y86_seq_ctrl
  import y86_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  y86_seq_ctrl_if.master  bus
);

  state_e           state_q, state_d;
  logic [2:0]       stat_q, stat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic valid, needs_mem, mem_rd, mem_wr_cls, writes_reg, sets_cc;
  logic ld_ir, ld_src, ld_valE, set_cc, ld_valM, rf_we, ld_pc, mem_req, mem_wr;

  y86_icode_class u_class (
    .icode_i      (bus.icode),
    .valid_o      (valid),
    .needs_mem_o  (needs_mem),
    .mem_rd_o     (mem_rd),
    .mem_wr_o     (mem_wr_cls),
    .writes_reg_o (writes_reg),
    .sets_cc_o    (sets_cc)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              mem_wait;
`endif

  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    cnt_d   = cnt_q;
    ld_ir   = 1'b0;
    ld_src  = 1'b0;
    ld_valE = 1'b0;
    set_cc  = 1'b0;
    ld_valM = 1'b0;
    rf_we   = 1'b0;
    ld_pc   = 1'b0;
    mem_req = 1'b0;
    mem_wr  = 1'b0;
    case (state_q)
      S_IDLE: if (bus.run) state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        // A bad address overrides a same-cycle completion.
        if (bus.mem_error) begin
          state_d = S_ERROR;
          stat_d  = STAT_ADR;
        end else if (bus.mem_ready) begin
          ld_ir   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ld_src = 1'b1;
        if (bus.icode == I_HALT) begin
          state_d = S_HALTED;
          stat_d  = STAT_HLT;
        end else if (!valid) begin
          state_d = S_ERROR;
          stat_d  = STAT_INS;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        ld_valE = 1'b1;
        set_cc  = sets_cc;
        if (needs_mem)       state_d = S_MEMORY;
        else if (writes_reg) state_d = S_WRBACK;
        else                 state_d = S_PCUPD;
      end
      S_MEMORY: begin
        mem_req = 1'b1;
        mem_wr  = mem_wr_cls;
        if (bus.mem_error) begin
          state_d = S_ERROR;
          stat_d  = STAT_ADR;
        end else if (bus.mem_ready) begin
          ld_valM = mem_rd;
          state_d = writes_reg ? S_WRBACK : S_PCUPD;
        end
      end
      S_WRBACK: begin
        rf_we   = 1'b1;
        state_d = S_PCUPD;
      end
      S_PCUPD: begin
        ld_pc   = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = bus.run ? S_FETCH : S_IDLE;
      end
      default: ;  // HALTED / ERROR are terminal until reset
    endcase

`ifdef MEM_TIMEOUT_EN
    // Counter only runs while a request is outstanding, so it restarts at zero for each
    // request (every request is preceded by a non-request state).
    mem_wait = mem_req && !bus.mem_ready && !bus.mem_error;
    wait_d   = '0;
    if (mem_wait) begin
      if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
        state_d = S_ERROR;
        stat_d  = STAT_ADR;
      end else begin
        wait_d = wait_q + WAIT_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      stat_q  <= STAT_AOK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wait_q <= '0;
    else       wait_q <= wait_d;
  end
`endif

  assign bus.ld_ir       = ld_ir;
  assign bus.ld_src      = ld_src;
  assign bus.ld_valE     = ld_valE;
  assign bus.set_cc      = set_cc;
  assign bus.ld_valM     = ld_valM;
  assign bus.rf_we       = rf_we;
  assign bus.ld_pc       = ld_pc;
  assign bus.mem_req     = mem_req;
  assign bus.mem_wr      = mem_wr;
  assign bus.stat        = stat_q;
  assign bus.busy        = (state_q != S_IDLE) && (state_q != S_HALTED) && (state_q != S_ERROR);
  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_y86_seq_ctrl.sv
// tb/tb_y86_seq_ctrl.sv - table-driven bench for the Y86 stage sequencer
module tb_y86_seq_ctrl;

  typedef struct {
    logic        run;
    logic [3:0]  icode;
    logic        rdy;
    logic        err;
    logic [8:0]  en;    // {ld_ir,ld_src,ld_valE,set_cc,ld_valM,rf_we,ld_pc,mem_req,mem_wr}
    logic        busy;
    logic [2:0]  stat;
    logic [31:0] cnt;
  } vec_t;

  localparam int NV = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_fail = 0;
  vec_t tbl [NV];

  y86_seq_ctrl_if #(.CNT_W(32)) bus ();

  y86_seq_ctrl #(.CNT_W(32), .TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic run, input logic [3:0] ic, input logic rdy,
                              input logic err, input logic [8:0] en, input logic busy,
                              input logic [2:0] st, input logic [31:0] cnt);
    vec_t v;
    v.run = run; v.icode = ic; v.rdy = rdy; v.err = err;
    v.en = en; v.busy = busy; v.stat = st; v.cnt = cnt;
    return v;
  endfunction

  // Drive inputs just after the falling edge, then let them settle before sampling.
  task automatic step(input logic run, input logic [3:0] ic, input logic rdy, input logic err);
    @(negedge clk);
    bus.run = run; bus.icode = ic; bus.mem_ready = rdy; bus.mem_error = err;
    #1;
  endtask

  task automatic cmp(input string nm, input logic [8:0] en, input logic busy,
                     input logic [2:0] st, input logic [31:0] cnt);
    logic [8:0] got;
    got = {bus.ld_ir, bus.ld_src, bus.ld_valE, bus.set_cc, bus.ld_valM,
           bus.rf_we, bus.ld_pc, bus.mem_req, bus.mem_wr};
    n_vec++;
    if (got !== en || bus.busy !== busy || bus.stat !== st || bus.instr_count !== cnt) begin
      n_fail++;
      $display("FAIL %s: got en=%b busy=%b stat=%0d cnt=%0d, expected en=%b busy=%b stat=%0d cnt=%0d",
               nm, got, bus.busy, bus.stat, bus.instr_count, en, busy, st, cnt);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.run = 1'b0; bus.icode = 4'h1; bus.mem_ready = 1'b0; bus.mem_error = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    // nop, mrmovl with 3 wait cycles, rmmovl, opl with one fetch wait, halt
    tbl[0]  = mk(0, 4'h1, 1, 0, 9'h000, 0, 1, 0);
    tbl[1]  = mk(1, 4'h1, 1, 0, 9'h000, 0, 1, 0);
    tbl[2]  = mk(1, 4'h1, 1, 0, 9'h102, 1, 1, 0);
    tbl[3]  = mk(1, 4'h1, 1, 0, 9'h080, 1, 1, 0);
    tbl[4]  = mk(1, 4'h1, 1, 0, 9'h040, 1, 1, 0);
    tbl[5]  = mk(1, 4'h5, 1, 0, 9'h004, 1, 1, 0);
    tbl[6]  = mk(1, 4'h5, 1, 0, 9'h102, 1, 1, 1);
    tbl[7]  = mk(1, 4'h5, 1, 0, 9'h080, 1, 1, 1);
    tbl[8]  = mk(1, 4'h5, 0, 0, 9'h040, 1, 1, 1);
    tbl[9]  = mk(1, 4'h5, 0, 0, 9'h002, 1, 1, 1);
    tbl[10] = mk(1, 4'h5, 0, 0, 9'h002, 1, 1, 1);
    tbl[11] = mk(1, 4'h5, 0, 0, 9'h002, 1, 1, 1);
    tbl[12] = mk(1, 4'h5, 1, 0, 9'h012, 1, 1, 1);
    tbl[13] = mk(1, 4'h4, 1, 0, 9'h008, 1, 1, 1);
    tbl[14] = mk(1, 4'h4, 1, 0, 9'h004, 1, 1, 1);
    tbl[15] = mk(1, 4'h4, 1, 0, 9'h102, 1, 1, 2);
    tbl[16] = mk(1, 4'h4, 1, 0, 9'h080, 1, 1, 2);
    tbl[17] = mk(1, 4'h4, 1, 0, 9'h040, 1, 1, 2);
    tbl[18] = mk(1, 4'h4, 1, 0, 9'h003, 1, 1, 2);
    tbl[19] = mk(1, 4'h6, 1, 0, 9'h004, 1, 1, 2);
    tbl[20] = mk(1, 4'h6, 0, 0, 9'h002, 1, 1, 3);
    tbl[21] = mk(1, 4'h6, 1, 0, 9'h102, 1, 1, 3);
    tbl[22] = mk(1, 4'h6, 1, 0, 9'h080, 1, 1, 3);
    tbl[23] = mk(1, 4'h6, 1, 0, 9'h060, 1, 1, 3);
    tbl[24] = mk(1, 4'h6, 1, 0, 9'h008, 1, 1, 3);
    tbl[25] = mk(0, 4'h6, 1, 0, 9'h004, 1, 1, 3);
    tbl[26] = mk(0, 4'h0, 1, 0, 9'h000, 0, 1, 4);
    tbl[27] = mk(1, 4'h0, 1, 0, 9'h000, 0, 1, 4);
    tbl[28] = mk(1, 4'h0, 1, 0, 9'h102, 1, 1, 4);
    tbl[29] = mk(1, 4'h0, 1, 0, 9'h080, 1, 1, 4);
    tbl[30] = mk(1, 4'h0, 1, 0, 9'h000, 0, 2, 4);
    tbl[31] = mk(1, 4'h0, 1, 0, 9'h000, 0, 2, 4);

    do_reset();
    for (int i = 0; i < NV; i++) begin
      step(tbl[i].run, tbl[i].icode, tbl[i].rdy, tbl[i].err);
      cmp($sformatf("vec%0d", i), tbl[i].en, tbl[i].busy, tbl[i].stat, tbl[i].cnt);
    end

    // Illegal icode 0xC -> ERROR with INS
    do_reset();
    step(1, 4'hC, 1, 0); cmp("ins_idle", 9'h000, 0, 1, 0);
    step(1, 4'hC, 1, 0); cmp("ins_fetch", 9'h102, 1, 1, 0);
    step(1, 4'hC, 1, 0); cmp("ins_decode", 9'h080, 1, 1, 0);
    step(1, 4'hC, 1, 0); cmp("ins_error", 9'h000, 0, 4, 0);
    step(1, 4'h1, 1, 0); cmp("ins_hold", 9'h000, 0, 4, 0);

    // mem_error beats mem_ready in FETCH
    do_reset();
    step(1, 4'h1, 0, 0); cmp("adr_idle", 9'h000, 0, 1, 0);
    step(1, 4'h1, 1, 1); cmp("adr_fetch", 9'h002, 1, 1, 0);
    step(1, 4'h1, 1, 0); cmp("adr_error", 9'h000, 0, 3, 0);

    // Asynchronous reset in the middle of EXECUTE, away from the clock edge
    do_reset();
    step(1, 4'h1, 1, 0);
    step(1, 4'h1, 1, 0);
    step(1, 4'h1, 1, 0);
    step(1, 4'h1, 1, 0); cmp("rst_exec", 9'h040, 1, 1, 0);
    #2 reset = 1'b1;
    #1 cmp("rst_async", 9'h000, 0, 1, 0);
    @(negedge clk);
    reset = 1'b0;

    // Memory never answers
    do_reset();
    step(1, 4'h1, 0, 0);
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      step(1, 4'h1, 0, 0); cmp($sformatf("to_wait%0d", i), 9'h002, 1, 1, 0);
    end
    step(1, 4'h1, 0, 0); cmp("to_error", 9'h000, 0, 3, 0);
`else
    for (int i = 0; i < 8; i++) begin
      step(1, 4'h1, 0, 0); cmp($sformatf("wait%0d", i), 9'h002, 1, 1, 0);
    end
    step(1, 4'h1, 1, 0); cmp("wait_done", 9'h102, 1, 1, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
